// File: rtl/turbo_pkg.sv
// Shared constants, state enum and RSC step function for the turbo encoder.
// TAIL_BITS follows the TURBO_ENC_TAIL_EN macro.
package turbo_pkg;

  localparam logic [2:0] GEN_FB = 3'o7;
  localparam logic [2:0] GEN_FF = 3'o5;

`ifdef TURBO_ENC_TAIL_EN
  localparam int TAIL_BITS = 2;
`else
  localparam int TAIL_BITS = 0;
`endif

  typedef enum logic [1:0] {
    LOAD,
    ENCODE,
    TAIL
  } state_t;

  // Returns {next_s1, next_s0, parity}; s[1] is the most recent delay stage.
  function automatic logic [2:0] rsc_step(input logic [1:0] s, input logic u);
    logic a;
    logic p;
    a = (GEN_FB[2] & u) ^ (GEN_FB[1] & s[1]) ^ (GEN_FB[0] & s[0]);
    p = (GEN_FF[2] & a) ^ (GEN_FF[1] & s[1]) ^ (GEN_FF[0] & s[0]);
    return {a, s[1], p};
  endfunction

endpackage

// File: rtl/turbo_qpp_addr.sv
// QPP interleaver address generator, pi(i) = (F1*i + F2*i*i) mod N, built
// incrementally so no multiplier is needed.
module turbo_qpp_addr #(
  parameter int N  = 64,
  parameter int F1 = 7,
  parameter int F2 = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  output logic [$clog2(N)-1:0] addr
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] G_INIT = AW'((F1 + F2) % N);
  localparam logic [AW-1:0] G_INC  = AW'((2 * F2) % N);

  logic [AW-1:0] r_pi;
  logic [AW-1:0] r_g;

  // N is a power of two, so the mod N is just the natural wrap of AW bits.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_pi <= '0;
      r_g  <= G_INIT;
    end else if (step) begin
      r_pi <= r_pi + r_g;
      r_g  <= r_g + G_INC;
    end
  end

  assign addr = r_pi;

endmodule

// File: rtl/turbo_encode.sv
// Rate-1/3 turbo encoder: buffers N bits, then streams sys/p1/p2 symbols.
// Define TURBO_ENC_TAIL_EN to append two RSC1 termination symbols.
module turbo_encode
  import turbo_pkg::*;
#(
  parameter int N  = 64,
  parameter int F1 = 7,
  parameter int F2 = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_p1,
  output logic out_p2,
  output logic out_last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t        r_state, w_stateNext;
  logic [N-1:0]  r_buf;
  logic [AW-1:0] r_cnt, r_idx, w_addr;
  logic [1:0]    r_rsc1, r_rsc2, w_rsc1Next, w_rsc2Next;
  logic [2:0]    w_rsc1Step, w_rsc2Step;
  logic          r_outValid, r_outSys, r_outP1, r_outP2, r_outLast;
  logic          w_accept, w_load, w_shift, w_last, w_slot, w_lastHs;
  logic          w_symSys, w_symP1, w_symP2;
`ifdef TURBO_ENC_TAIL_EN
  logic          r_tailCnt, w_tailLoad;
  logic [2:0]    w_tailStep;
`endif

  turbo_qpp_addr #(.N(N), .F1(F1), .F2(F2)) u_qpp (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_lastHs),
    .step  (w_load),
    .addr  (w_addr)
  );

  assign w_slot     = !r_outValid || out_ready;
  assign w_lastHs   = r_outValid && r_outLast && out_ready;
  assign w_rsc1Step = rsc_step(r_rsc1, r_buf[r_idx]);
  assign w_rsc2Step = rsc_step(r_rsc2, r_buf[w_addr]);
`ifdef TURBO_ENC_TAIL_EN
  // Feeding u = s1^s0 forces a = 0, flushing RSC1 to 00 in two steps.
  assign w_tailStep = rsc_step(r_rsc1, r_rsc1[1] ^ r_rsc1[0]);
  assign w_shift    = w_load || w_tailLoad;
`else
  assign w_shift    = w_load;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_last      = 1'b0;
    w_symSys    = r_buf[r_idx];
    w_symP1     = w_rsc1Step[0];
    w_symP2     = w_rsc2Step[0];
    w_rsc1Next  = w_rsc1Step[2:1];
    w_rsc2Next  = w_rsc2Step[2:1];
`ifdef TURBO_ENC_TAIL_EN
    w_tailLoad  = 1'b0;
`endif
    case (r_state)
      LOAD: begin
        in_ready = rst_n;
        w_accept = in_valid && rst_n;
        // Symbol 0 loads on the Nth accept; pi(0)=0 so buffer[0] is ready.
        if (w_accept && r_cnt == LAST_IDX) begin
          w_load      = 1'b1;
          w_stateNext = ENCODE;
        end
      end
      ENCODE: begin
        if (w_lastHs) begin
          w_stateNext = LOAD;
        end else if (!r_outLast && w_slot) begin
          w_load = 1'b1;
          if (r_idx == LAST_IDX) begin
`ifdef TURBO_ENC_TAIL_EN
            w_stateNext = TAIL;
`else
            w_last = 1'b1;
`endif
          end
        end
      end
`ifdef TURBO_ENC_TAIL_EN
      TAIL: begin
        if (w_lastHs) begin
          w_stateNext = LOAD;
        end else if (!r_outLast && w_slot) begin
          w_tailLoad = 1'b1;
          w_symSys   = r_rsc1[1] ^ r_rsc1[0];
          w_symP1    = w_tailStep[0];
          w_symP2    = 1'b0;
          w_rsc1Next = w_tailStep[2:1];
          w_last     = (r_tailCnt == 1'(TAIL_BITS - 1));
        end
      end
`endif
      default: w_stateNext = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_cnt] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rsc1     <= '0;
      r_rsc2     <= '0;
      r_outValid <= 1'b0;
      r_outSys   <= 1'b0;
      r_outP1    <= 1'b0;
      r_outP2    <= 1'b0;
      r_outLast  <= 1'b0;
`ifdef TURBO_ENC_TAIL_EN
      r_tailCnt  <= 1'b0;
`endif
    end else begin
      if (w_accept) r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
      if (w_lastHs) begin
        r_idx      <= '0;
        r_rsc1     <= '0;
        r_rsc2     <= '0;
        r_outValid <= 1'b0;
        r_outSys   <= 1'b0;
        r_outP1    <= 1'b0;
        r_outP2    <= 1'b0;
        r_outLast  <= 1'b0;
`ifdef TURBO_ENC_TAIL_EN
        r_tailCnt  <= 1'b0;
`endif
      end else if (w_shift) begin
        r_rsc1     <= w_rsc1Next;
        r_outValid <= 1'b1;
        r_outSys   <= w_symSys;
        r_outP1    <= w_symP1;
        r_outP2    <= w_symP2;
        r_outLast  <= w_last;
        if (w_load) begin
          r_rsc2 <= w_rsc2Next;
          r_idx  <= r_idx + 1'b1;
        end
`ifdef TURBO_ENC_TAIL_EN
        if (w_tailLoad) r_tailCnt <= r_tailCnt + 1'b1;
`endif
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_sys   = r_outSys;
  assign out_p1    = r_outP1;
  assign out_p2    = r_outP2;
  assign out_last  = r_outLast;

endmodule

// File: tb/tb_turbo_encode.sv
// Directed bench for turbo_encode: reference-model symbol checks, stalls,
// mid-block reset and back-to-back blocks. Honours TURBO_ENC_TAIL_EN.
module tb_turbo_encode;

  localparam int N  = 64;
  localparam int F1 = 7;
  localparam int F2 = 16;
`ifdef TURBO_ENC_TAIL_EN
  localparam int NTAIL = 2;
`else
  localparam int NTAIL = 0;
`endif
  localparam int NSYM = N + NTAIL;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_bit;
  logic out_valid, out_ready, out_sys, out_p1, out_p2, out_last;

  int nChecks = 0;
  int nFails  = 0;

  logic [3:0] expSym [N+2];
  logic [3:0] obsSym [N+2];

  turbo_encode #(.N(N), .F1(F1), .F2(F2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sys   (out_sys),
    .out_p1    (out_p1),
    .out_p2    (out_p2),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference encoder using the closed-form interleaver.
  function automatic void buildModel(input logic [N-1:0] blk);
    logic s1a, s0a, s1b, s0b, u, v, a, p1, p2;
    s1a = 0; s0a = 0; s1b = 0; s0b = 0;
    for (int i = 0; i < N; i++) begin
      u = blk[i];
      a = u ^ s1a ^ s0a; p1 = a ^ s0a; s0a = s1a; s1a = a;
      v = blk[(F1 * i + F2 * i * i) % N];
      a = v ^ s1b ^ s0b; p2 = a ^ s0b; s0b = s1b; s1b = a;
      expSym[i] = {u, p1, p2, (i == N - 1) && (NTAIL == 0)};
    end
    for (int t = 0; t < NTAIL; t++) begin
      u = s1a ^ s0a;
      p1 = s0a;
      s0a = s1a;
      s1a = 1'b0;
      expSym[N + t] = {u, p1, 1'b0, t == NTAIL - 1};
    end
  endfunction

  task automatic applyStimulus(input logic [N-1:0] blk, input int count, input bit keep);
    int k = 0;
    int guard = 0;
    while (k < count && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_bit   = blk[k];
      if (in_ready) k++;
    end
    if (k < count) checkOutput("inTimeout", k, count);
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic checkBlock(input logic [N-1:0] blk, input int stallAt);
    int sym = 0;
    int cyc = 0;
    int stallLeft = 5;
    bit seenValid = 0;
    bit badReady = 0;
    logic [3:0] cur;
    logic [3:0] held = '0;
    buildModel(blk);
    out_ready = 1'b1;
    while (sym < NSYM && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      cur = {out_sys, out_p1, out_p2, out_last};
      if (out_valid) seenValid = 1;
      if (seenValid && in_ready) badReady = 1;
      if (out_valid && sym == stallAt && stallLeft > 0) begin
        if (stallLeft == 5) held = cur;
        else checkOutput("stallHold", {out_valid, cur}, {1'b1, held});
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          obsSym[sym] = cur;
          checkOutput($sformatf("sym%0d", sym), cur, expSym[sym]);
          sym++;
        end
      end
    end
    if (sym < NSYM) checkOutput("outTimeout", sym, NSYM);
    checkOutput("inReadyLow", badReady, 0);
    @(negedge clk);
    checkOutput("idleAfterLast", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic runBlock(input logic [N-1:0] blk, input int stallAt);
    fork
      applyStimulus(blk, N, 1'b0);
      checkBlock(blk, stallAt);
    join
  endtask

  initial begin
    logic [6:0] gotP1, gotP2;
    logic [2:0] gotSys;
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetOut", {out_valid, out_sys, out_p1, out_p2, out_last}, 5'b0);
    checkOutput("resetReady", in_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", in_ready, 1'b1);

    runBlock(64'h0, -1);

    runBlock(64'h1, -1);
    for (int i = 0; i < 7; i++) begin
      gotP1[6 - i] = obsSym[i][2];
      gotP2[6 - i] = obsSym[i][1];
    end
    for (int i = 0; i < 3; i++) gotSys[2 - i] = obsSym[i][3];
    checkOutput("bit0P1", gotP1, 7'b1110110);
    checkOutput("bit0P2", gotP2, 7'b1110110);
    checkOutput("bit0Sys", gotSys, 3'b100);

    runBlock(64'hA5C3_1F0E_9B27_64D8, 20);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 30, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetOut", {out_valid, in_ready}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midResetReady", in_ready, 1'b1);
    runBlock(64'h0123_4567_89AB_CDEF, -1);

    fork
      begin
        applyStimulus(64'hDEAD_BEEF_0F1E_2D3C, N, 1'b1);
        applyStimulus(64'h5A5A_C3C3_9696_0FF0, N, 1'b0);
      end
      begin
        checkBlock(64'hDEAD_BEEF_0F1E_2D3C, -1);
        checkBlock(64'h5A5A_C3C3_9696_0FF0, -1);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
